imem_loader: RTL

Program loader that writes a byte stream into the single-cycle CPU's instruction memory. It holds the CPU in reset until the load completes. It sits between a byte source (bench, UART receiver or debug port) and the IRAM write port. It packs bytes into 32-bit words, writes them at consecutive word addresses from 0, and releases `cpu_reset` once the last word is committed. It is the writer side of the instruction fetch path that the CPU reads.

---
 rtl/imem_loader.sv | 130 +++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: packs a byte stream little-endian into 32-bit words and writes
// them to IRAM from word address 0. The CPU is held in reset until the load ends.
//   clk, reset            clock and synchronous active-high reset
//   load_start            restart the load from address 0
//   in_valid/in_data/in_last/in_ready   byte source handshake
//   imem_we/imem_addr/imem_wdata        IRAM write port
//   cpu_reset, done, error, word_count  load status
module imem_loader #(
  parameter int unsigned MEM_DEPTH = 256,
  localparam int unsigned AW = $clog2(MEM_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  input  logic          in_last,
  output logic          in_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_reset,
  output logic          done,
  output logic          error,
  output logic [AW:0]   word_count
);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_DONE  = 2'd1,
    S_ERROR = 2'd2
  } state_t;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(MEM_DEPTH);

  state_t        state, state_n;
  logic [1:0]    lane, lane_n;
  logic [31:0]   asm_q, asm_n;
  logic [31:0]   word_c;
  logic          we_n, done_n, error_n, cpu_reset_n;
  logic [AW-1:0] addr_n;
  logic [31:0]   wdata_n;
  logic [AW:0]   wc_n;
  logic          accept;

  // Ready depends only on registered state and reset.
  assign in_ready = (state == S_LOAD) && !reset;
  assign accept   = in_valid && in_ready;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_LOAD;
      lane       <= 2'd0;
      asm_q      <= 32'd0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
    end else begin
      state      <= state_n;
      lane       <= lane_n;
      asm_q      <= asm_n;
      imem_we    <= we_n;
      imem_addr  <= addr_n;
      imem_wdata <= wdata_n;
      cpu_reset  <= cpu_reset_n;
      done       <= done_n;
      error      <= error_n;
      word_count <= wc_n;
    end
  end

  // Next-state, byte packing and write scheduling.
  always_comb begin
    state_n     = state;
    lane_n      = lane;
    asm_n       = asm_q;
    we_n        = 1'b0;
    addr_n      = imem_addr;
    wdata_n     = imem_wdata;
    wc_n        = word_count;
    // done/cpu_reset follow the state one cycle late, so they change after
    // the final write pulse rather than alongside it.
    done_n      = (state == S_DONE);
    error_n     = (state == S_ERROR);
    cpu_reset_n = (state != S_DONE);

    // Upper lanes of asm_q are still zero, which gives the padding for a
    // short final word.
    word_c = asm_q;
    case (lane)
      2'd0:    word_c[7:0]   = in_data;
      2'd1:    word_c[15:8]  = in_data;
      2'd2:    word_c[23:16] = in_data;
      default: word_c[31:24] = in_data;
    endcase

    if (load_start) begin
      // Any byte accepted this cycle is dropped and no write is issued.
      state_n     = S_LOAD;
      lane_n      = 2'd0;
      asm_n       = 32'd0;
      wc_n        = '0;
      done_n      = 1'b0;
      error_n     = 1'b0;
      cpu_reset_n = 1'b1;
    end else if (accept) begin
      if (word_count == DEPTH_W) begin
        state_n = S_ERROR;
        error_n = 1'b1;
      end else if (lane == 2'd3 || in_last) begin
        we_n    = 1'b1;
        addr_n  = word_count[AW-1:0];
        wdata_n = word_c;
        wc_n    = word_count + (AW+1)'(1);
        lane_n  = 2'd0;
        asm_n   = 32'd0;
        if (in_last) state_n = S_DONE;
      end else begin
        asm_n  = word_c;
        lane_n = lane + 2'd1;
      end
    end
  end

endmodule
